// File: rtl/s27_scan_array.sv
// s27_scan_array: CHANNELS independent ISCAS s27 cores sharing one scan chain
// and a saturating counter of edges on which any core drives G17 low.
//
// Ports:
//   CK            clock, rising edge
//   RST           asynchronous active-high reset
//   G0..G3        per-channel primary inputs, bit c belongs to channel c
//   EN            functional-update enable (0 = hold)
//   SE            scan enable, overrides EN
//   SI / SO       serial scan in / out (SO = last Q2)
//   G17           per-channel output, combinational or registered (REG_OUT)
//   LOWCNT        saturating count of functional edges with any N17 low
module s27_scan_array #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int REG_OUT  = 0
) (
    input  logic                CK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] G0,
    input  logic [CHANNELS-1:0] G1,
    input  logic [CHANNELS-1:0] G2,
    input  logic [CHANNELS-1:0] G3,
    input  logic                EN,
    input  logic                SE,
    input  logic                SI,
    output logic                SO,
    output logic [CHANNELS-1:0] G17,
    output logic [CNT_W-1:0]    LOWCNT
);

    logic [CHANNELS-1:0] r_q0;
    logic [CHANNELS-1:0] r_q1;
    logic [CHANNELS-1:0] r_q2;
    logic [CNT_W-1:0]    r_cnt;

    logic [CHANNELS-1:0] w_x;
    logic [CHANNELS-1:0] w_d0;
    logic [CHANNELS-1:0] w_d1;
    logic [CHANNELS-1:0] w_d2;
    logic [CHANNELS-1:0] w_n17;
    logic [CHANNELS:0]   w_shift_src;
    logic                w_func;
    logic                w_any_low;
    logic                w_cnt_max;

    // Bitwise across channels: each bit position is one independent core.
    assign w_x   = (~G0 & r_q1) | (~G1 & ~r_q2 & G3);
    assign w_d1  = w_x & ~r_q0;
    assign w_n17 = ~w_d1;
    assign w_d0  = G0 & w_n17;
    assign w_d2  = (G1 | r_q2) & ~G2;

    // Q0[c] is fed by Q2[c-1]; SI enters at Q0[0].
    assign w_shift_src = {r_q2, SI};

    assign w_func    = ~SE & EN;
    assign w_any_low = ~&w_n17;
    assign w_cnt_max = &r_cnt;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_q0 <= '0;
            r_q1 <= '0;
            r_q2 <= '0;
        end else if (SE) begin
            r_q0 <= w_shift_src[CHANNELS-1:0];
            r_q1 <= r_q0;
            r_q2 <= r_q1;
        end else if (EN) begin
            r_q0 <= w_d0;
            r_q1 <= w_d1;
            r_q2 <= w_d2;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_func && w_any_low && !w_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [CHANNELS-1:0] r_g17;

            // Off the scan chain; only functional edges refresh it.
            always_ff @(posedge CK or posedge RST) begin
                if (RST) begin
                    r_g17 <= '1;
                end else if (w_func) begin
                    r_g17 <= w_n17;
                end
            end

            assign G17 = r_g17;
        end else begin : g_comb_out
            assign G17 = w_n17;
        end
    endgenerate

    assign SO     = r_q2[CHANNELS-1];
    assign LOWCNT = r_cnt;

endmodule

// File: tb/tb_s27_scan_array.sv
// Scoreboard bench for s27_scan_array: a bit-vector reference model predicts
// every cycle, a negedge monitor compares both REG_OUT variants.
module tb_s27_scan_array;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int NB = 3 * CH;
    localparam int CMAX = (1 << CW) - 1;

    logic          CK = 1'b0;
    logic          RST;
    logic          EN;
    logic          SE;
    logic          SI;
    logic [CH-1:0] G0;
    logic [CH-1:0] G1;
    logic [CH-1:0] G2;
    logic [CH-1:0] G3;
    logic          SO0;
    logic          SO1;
    logic [CH-1:0] G17_0;
    logic [CH-1:0] G17_1;
    logic [CW-1:0] CNT0;
    logic [CW-1:0] CNT1;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    s27_scan_array #(.CHANNELS(CH), .CNT_W(CW), .REG_OUT(0)) u_d0 (
        .CK(CK), .RST(RST), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
        .EN(EN), .SE(SE), .SI(SI), .SO(SO0), .G17(G17_0), .LOWCNT(CNT0)
    );

    s27_scan_array #(.CHANNELS(CH), .CNT_W(CW), .REG_OUT(1)) u_d1 (
        .CK(CK), .RST(RST), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
        .EN(EN), .SE(SE), .SI(SI), .SO(SO1), .G17(G17_1), .LOWCNT(CNT1)
    );

    typedef struct {
        logic          so;
        logic [CH-1:0] g17c;
        logic [CH-1:0] g17r;
        logic [CH-1:0] q0;
        logic [CH-1:0] q1;
        logic [CH-1:0] q2;
        int            cnt;
    } exp_t;

    exp_t sb[$];

    // Model state: whole scan chain as one vector, index 3c+k holds Qk[c].
    bit [NB-1:0] st;
    bit [CH-1:0] m_g17r;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit [CH-1:0] model_n17();
        bit [CH-1:0] n;
        bit q0, q1, q2, x;
        for (int c = 0; c < CH; c++) begin
            q0 = st[3*c];
            q1 = st[3*c+1];
            q2 = st[3*c+2];
            x = (!G0[c] && q1) || (!G1[c] && !q2 && G3[c]);
            n[c] = !(x && !q0);
        end
        return n;
    endfunction

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic step();
        exp_t e;
        bit [CH-1:0] n;
        bit [NB-1:0] nst;
        if (RST) begin
            st = '0;
            m_cnt = 0;
            m_g17r = '1;
        end
        n = model_n17();
        e.so = st[NB-1];
        e.g17c = n;
        e.g17r = m_g17r;
        e.cnt = m_cnt;
        for (int c = 0; c < CH; c++) begin
            e.q0[c] = st[3*c];
            e.q1[c] = st[3*c+1];
            e.q2[c] = st[3*c+2];
        end
        sb.push_back(e);
        if (!RST) begin
            if (SE) begin
                st = {st[NB-2:0], SI};
            end else if (EN) begin
                nst = st;
                for (int c = 0; c < CH; c++) begin
                    nst[3*c+1] = !n[c];
                    nst[3*c]   = G0[c] && n[c];
                    nst[3*c+2] = (G1[c] || st[3*c+2]) && !G2[c];
                end
                st = nst;
                m_g17r = n;
                if (n != '1 && m_cnt < CMAX) m_cnt++;
            end
        end
        @(posedge CK);
        #1;
    endtask

    always @(negedge CK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("so", {31'd0, SO0}, {31'd0, e.so});
            chk("so_reg", {31'd0, SO1}, {31'd0, e.so});
            chk("g17_comb", {28'd0, G17_0}, {28'd0, e.g17c});
            chk("g17_reg", {28'd0, G17_1}, {28'd0, e.g17r});
            chk("lowcnt", {24'd0, CNT0}, e.cnt);
            chk("lowcnt_reg", {24'd0, CNT1}, e.cnt);
            chk("q0", {28'd0, u_d0.r_q0}, {28'd0, e.q0});
            chk("q1", {28'd0, u_d0.r_q1}, {28'd0, e.q1});
            chk("q2", {28'd0, u_d0.r_q2}, {28'd0, e.q2});
        end
    end

    task automatic idle_inputs();
        G0 = '0; G1 = '0; G2 = '0; G3 = '0;
        EN = 1'b0; SE = 1'b0; SI = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    // Channel 0 in the state that keeps N17[0] low forever.
    task automatic ch0_low();
        G0[0] = 1'b0; G1[0] = 1'b0; G2[0] = 1'b0; G3[0] = 1'b1;
    endtask

    initial begin
        logic [11:0] pat;
        pat = 12'b101100110101;
        idle_inputs();
        RST = 1'b1;
        st = '0;
        m_cnt = 0;
        m_g17r = '1;
        @(posedge CK);
        #1;
        step();
        step();
        RST = 1'b0;

        // Scenario 1 on channel 0.
        ch0_low();
        EN = 1'b1;
        #1;
        chk("s1_g17_immediate", {31'd0, G17_0[0]}, 32'd0);
        chk("s1_g17_reg_reset", {31'd0, G17_1[0]}, 32'd1);
        step();
        step();
        chk("s1_g17_reg_fell", {31'd0, G17_1[0]}, 32'd0);
        step();

        // Scenario 2 on channel 1.
        do_reset();
        idle_inputs();
        G0[1] = 1'b1; G1[1] = 1'b1; EN = 1'b1;
        #1;
        chk("s2_g17", {31'd0, G17_0[1]}, 32'd1);
        step();
        step();

        // Scan shift of the pattern followed by flush zeros.
        do_reset();
        idle_inputs();
        SE = 1'b1;
        for (int i = 0; i < 24; i++) begin
            SI = (i < 12) ? pat[11-i] : 1'b0;
            EN = $urandom_range(0, 1);
            G0 = $urandom; G1 = $urandom; G2 = $urandom; G3 = $urandom;
            step();
        end

        // Reset landing mid-scan, held across an edge with SE=1.
        for (int i = 0; i < 6; i++) begin
            SI = $urandom_range(0, 1);
            step();
        end
        RST = 1'b1;
        SI = 1'b1;
        step();
        step();
        RST = 1'b0;

        // Saturation, then hold.
        idle_inputs();
        ch0_low();
        EN = 1'b1;
        for (int i = 0; i < 300; i++) begin
            G0[3:1] = $urandom; G1[3:1] = $urandom;
            G2[3:1] = $urandom; G3[3:1] = $urandom;
            step();
        end
        chk("lowcnt_saturated", {24'd0, CNT0}, CMAX);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("lowcnt_hold", {24'd0, CNT0}, CMAX);

        // Reset landing mid-count, held across a functional edge.
        EN = 1'b1;
        for (int i = 0; i < 20; i++) step();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            G0 = $urandom; G1 = $urandom; G2 = $urandom; G3 = $urandom;
            SE = ($urandom_range(0, 3) == 0);
            EN = ($urandom_range(0, 3) != 0);
            SI = $urandom_range(0, 1);
            RST = ($urandom_range(0, 39) == 0);
            step();
        end
        RST = 1'b0;
        idle_inputs();
        step();

        repeat (3) @(negedge CK);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
